// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX session scheduler.
package fix_pkg;

  // Per-session connection state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CONN  = 2'd1,
    LOGON_PEND = 2'd2,
    ACTIVE     = 2'd3
  } sess_state_t;

  // Outbound message type; TX_NONE is only seen while no request was ever issued.
  typedef enum logic [1:0] {
    TX_NONE   = 2'b00,
    LOGON     = 2'b01,
    HEARTBEAT = 2'b10
  } tx_type_t;

  // Outbound channel FSM state, kept as plain constants.
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE = 2'd0;
  localparam tx_state_t TX_REQ  = 2'd1;
  localparam tx_state_t TX_BUSY = 2'd2;

  // Heartbeat interval (clk cycles) in force after reset.
  localparam int HB_DEFAULT = 30;

endpackage

// File: rtl/fix_rr_arbiter.sv
// Round-robin pick: first requesting host strictly after rr_ptr_i, wrapping.
module fix_rr_arbiter #(
  parameter int NUM_HOSTS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic [NUM_HOSTS-1:0] req_i,
  input  logic [ADDR_W-1:0]    rr_ptr_i,
  output logic [ADDR_W-1:0]    grant_o,
  output logic                 any_grant_o
);

  logic [ADDR_W-1:0] cand;

  // Scan ptr+1 .. ptr+NUM_HOSTS (mod NUM_HOSTS); the last candidate is ptr itself.
  always_comb begin
    grant_o     = '0;
    any_grant_o = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_HOSTS; i++) begin
      cand = rr_ptr_i + ADDR_W'(i);
      if (!any_grant_o && req_i[cand]) begin
        grant_o     = cand;
        any_grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fix_session_scheduler.sv
// Initiator-side FIX session sequencer: per-session connection state, logon and
// heartbeat scheduling, and round-robin ownership of the single outbound channel.
module fix_session_scheduler #(
  parameter int NUM_HOSTS  = 8,
  parameter int ADDR_W     = 3,
  parameter int HB_W       = 16,
  parameter int HB_DEFAULT = fix_pkg::HB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 configure_i,
  input  logic [HB_W-1:0]      hb_interval_i,
  input  logic                 connect_i,
  input  logic [ADDR_W-1:0]    connect_to_addr_i,
  input  logic                 connected_i,
  input  logic                 disconnect_i,
  input  logic [ADDR_W-1:0]    connected_host_addr_i,
  output logic                 connect_req_o,
  output logic [ADDR_W-1:0]    connect_host_addr_o,
  output logic                 connect_err_o,
  output logic                 tx_req_o,
  output logic [1:0]           tx_type_o,
  output logic [ADDR_W-1:0]    tx_host_o,
  input  logic                 tx_ack_i,
  input  logic                 tx_done_i,
  output logic [NUM_HOSTS-1:0] sess_active_o
);

  import fix_pkg::*;

  sess_state_t          sess_q [NUM_HOSTS];
  logic [HB_W-1:0]      hb_cnt_q [NUM_HOSTS];
  logic [HB_W-1:0]      hb_interval_q;
  logic [NUM_HOSTS-1:0] logon_due_q;
  logic [NUM_HOSTS-1:0] hb_due_q;

  tx_state_t            tx_state_q;
  logic                 tx_abort_q;
  logic [ADDR_W-1:0]    rr_ptr_q;

  logic [NUM_HOSTS-1:0] disc_vec;
  logic [NUM_HOSTS-1:0] conn_vec;
  logic [NUM_HOSTS-1:0] up_vec;
  logic [NUM_HOSTS-1:0] load_vec;
  logic [NUM_HOSTS-1:0] logon_done_vec;
  logic [NUM_HOSTS-1:0] ack_logon_vec;
  logic [NUM_HOSTS-1:0] ack_hb_vec;
  logic [NUM_HOSTS-1:0] hb_expire_vec;
  logic [NUM_HOSTS-1:0] req_vec;

  logic                 tx_host_disc;
  logic                 tx_drop;
  logic                 tx_ack_ok;
  logic                 tx_done_ok;
  logic                 target_idle;
  logic [ADDR_W-1:0]    grant_idx;
  logic                 any_grant;

  // A disconnect of the host currently owning the channel changes how the FSM
  // treats ack/done; a done after such a disconnect must not touch session state.
  assign tx_host_disc = disconnect_i && (connected_host_addr_i == tx_host_o);
  assign tx_drop      = (tx_state_q == TX_REQ) && tx_host_disc;
  assign tx_ack_ok    = (tx_state_q == TX_REQ) && tx_ack_i && !tx_host_disc;
  assign tx_done_ok   = (tx_state_q == TX_BUSY) && tx_done_i && !tx_abort_q && !tx_host_disc;
  assign target_idle  = (sess_q[connect_to_addr_i] == IDLE);

  // Hosts being disconnected this cycle are not eligible for a grant.
  assign req_vec = (logon_due_q | hb_due_q) & ~disc_vec;

  fix_rr_arbiter #(
    .NUM_HOSTS (NUM_HOSTS),
    .ADDR_W    (ADDR_W)
  ) u_arb (
    .req_i       (req_vec),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant_idx),
    .any_grant_o (any_grant)
  );

  // Decode the shared address buses and channel events into per-host strobes.
  always_comb begin
    disc_vec       = '0;
    conn_vec       = '0;
    up_vec         = '0;
    load_vec       = '0;
    logon_done_vec = '0;
    ack_logon_vec  = '0;
    ack_hb_vec     = '0;
    hb_expire_vec  = '0;
    sess_active_o  = '0;
    for (int h = 0; h < NUM_HOSTS; h++) begin
      disc_vec[h]       = disconnect_i && (connected_host_addr_i == ADDR_W'(h));
      conn_vec[h]       = connect_i && (connect_to_addr_i == ADDR_W'(h));
      up_vec[h]         = connected_i && (connected_host_addr_i == ADDR_W'(h));
      load_vec[h]       = tx_done_ok && (tx_host_o == ADDR_W'(h));
      logon_done_vec[h] = load_vec[h] && (tx_type_o == LOGON);
      ack_logon_vec[h]  = tx_ack_ok && (tx_host_o == ADDR_W'(h)) && (tx_type_o == LOGON);
      ack_hb_vec[h]     = tx_ack_ok && (tx_host_o == ADDR_W'(h)) && (tx_type_o == HEARTBEAT);
      hb_expire_vec[h]  = (sess_q[h] == ACTIVE) && (hb_cnt_q[h] == HB_W'(1)) && !load_vec[h];
      sess_active_o[h]  = (sess_q[h] == ACTIVE);
    end
  end

  // Session state machines; disconnect overrides every other event on that host.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        sess_q[h] <= IDLE;
      end
    end else begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        if (disc_vec[h]) begin
          sess_q[h] <= IDLE;
        end else begin
          case (sess_q[h])
            IDLE:       if (conn_vec[h])       sess_q[h] <= WAIT_CONN;
            WAIT_CONN:  if (up_vec[h])         sess_q[h] <= LOGON_PEND;
            LOGON_PEND: if (logon_done_vec[h]) sess_q[h] <= ACTIVE;
            default:    ;
          endcase
        end
      end
    end
  end

  // Connect request / error pulses toward the TCP layer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      connect_req_o       <= 1'b0;
      connect_err_o       <= 1'b0;
      connect_host_addr_o <= '0;
    end else begin
      connect_req_o <= connect_i && target_idle;
      connect_err_o <= connect_i && !target_idle;
      if (connect_i && target_idle) begin
        connect_host_addr_o <= connect_to_addr_i;
      end
    end
  end

  // Pending-message flags; a due flag is consumed when its request is acked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      logon_due_q <= '0;
      hb_due_q    <= '0;
    end else begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        if (disc_vec[h]) begin
          logon_due_q[h] <= 1'b0;
          hb_due_q[h]    <= 1'b0;
        end else begin
          if (up_vec[h] && (sess_q[h] == WAIT_CONN)) begin
            logon_due_q[h] <= 1'b1;
          end else if (ack_logon_vec[h]) begin
            logon_due_q[h] <= 1'b0;
          end
          if (hb_expire_vec[h]) begin
            hb_due_q[h] <= 1'b1;
          end else if (ack_hb_vec[h]) begin
            hb_due_q[h] <= 1'b0;
          end
        end
      end
    end
  end

  // Heartbeat interval register; new values apply only at the next counter load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb_interval_q <= HB_W'(HB_DEFAULT);
    end else if (configure_i) begin
      hb_interval_q <= hb_interval_i;
    end
  end

  // Heartbeat down-counters: reload on each completed message, count while ACTIVE, hold at 0.
  // They need no reset because every entry into ACTIVE goes through a reload.
  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HOSTS; h++) begin
      if (load_vec[h]) begin
        hb_cnt_q[h] <= hb_interval_q;
      end else if ((sess_q[h] == ACTIVE) && (hb_cnt_q[h] != '0)) begin
        hb_cnt_q[h] <= hb_cnt_q[h] - 1'b1;
      end
    end
  end

  // Outbound channel FSM: arbitrate, hold request until ack, then wait for done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_req_o   <= 1'b0;
      tx_type_o  <= TX_NONE;
      tx_host_o  <= '0;
      tx_abort_q <= 1'b0;
      rr_ptr_q   <= ADDR_W'(NUM_HOSTS - 1);
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (any_grant) begin
            tx_req_o   <= 1'b1;
            tx_host_o  <= grant_idx;
            tx_type_o  <= logon_due_q[grant_idx] ? LOGON : HEARTBEAT;
            tx_state_q <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (tx_drop) begin
            tx_req_o   <= 1'b0;
            tx_state_q <= TX_IDLE;
          end else if (tx_ack_i) begin
            tx_req_o   <= 1'b0;
            rr_ptr_q   <= tx_host_o;
            tx_abort_q <= 1'b0;
            tx_state_q <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done_i) begin
            tx_abort_q <= 1'b0;
            tx_state_q <= TX_IDLE;
          end else if (tx_host_disc) begin
            tx_abort_q <= 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

endmodule
